// File: rtl/pong_pkg.sv
// Shared types and grid constants for the pong game controller.
package pong_pkg;

    typedef enum logic [1:0] {
        ST_OVER  = 2'd0,
        ST_SERVE = 2'd1,
        ST_PLAY  = 2'd2
    } state_t;

    localparam int GRID_W      = 4;
    localparam int GRID_MAX    = 15;
    localparam int BALL_CENTRE = 7;

endpackage

// File: rtl/pong_paddle.sv
// One paddle: saturating position register plus registered row-occupancy mask.
module pong_paddle
    import pong_pkg::*;
#(
    parameter int PADDLE_H = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     tick,
    input  logic                     en,
    input  logic                     centre,
    input  logic                     up,
    input  logic                     dn,
    output logic [(1<<GRID_W)-1:0]   mask
);

    localparam int                    ROWS  = 1 << GRID_W;
    localparam logic [GRID_W-1:0]     P_MAX = GRID_W'(ROWS - PADDLE_H);
    localparam logic [GRID_W-1:0]     P_CTR = GRID_W'((ROWS - PADDLE_H) / 2);
    localparam logic [ROWS-1:0]       BASE  = ROWS'((32'd1 << PADDLE_H) - 32'd1);

    logic [GRID_W-1:0] pos_q, pos_d;
    logic [ROWS-1:0]   mask_q, mask_d;

    always_comb begin
        pos_d = pos_q;
        if (tick) begin
            if (centre) begin
                pos_d = P_CTR;
            end else if (en) begin
                if (up && !dn && pos_q != '0)
                    pos_d = pos_q - 1'b1;
                else if (dn && !up && pos_q != P_MAX)
                    pos_d = pos_q + 1'b1;
            end
        end
        mask_d = BASE << pos_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pos_q  <= P_CTR;
            mask_q <= BASE << P_CTR;
        end else begin
            pos_q  <= pos_d;
            mask_q <= mask_d;
        end
    end

    assign mask = mask_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game controller: frame-tick driven FSM, ball motion, scoring and two paddles.
// Optional PONG_AUTOPADDLE_EN makes the right paddle track the ball row instead of r_up/r_dn.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int BALL_DIV     = 4,
    parameter int PADDLE_H     = 3,
    parameter int SERVE_FRAMES = 60,
    parameter int WIN_SCORE    = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vsync,
    input  logic        start,
    input  logic        l_up,
    input  logic        l_dn,
    input  logic        r_up,
    input  logic        r_dn,
    output logic [3:0]  ball_x,
    output logic [3:0]  ball_y,
    output logic [15:0] lpaddle,
    output logic [15:0] rpaddle,
    output logic [3:0]  score_l,
    output logic [3:0]  score_r,
    output logic        game_over
);

    localparam int                FC_W    = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
    localparam logic [FC_W-1:0]   FC_LAST = FC_W'(SERVE_FRAMES - 1);
    localparam logic [3:0]        SC_LAST = 4'(BALL_DIV - 1);
    localparam logic [GRID_W-1:0] CTR     = GRID_W'(BALL_CENTRE);
    localparam logic [GRID_W-1:0] GMAX    = GRID_W'(GRID_MAX);
    localparam logic [3:0]        WIN     = 4'(WIN_SCORE);

    // Edge detector resets to "high seen" so a fresh low sample is needed before the first tick.
    logic vs_q, vs_prev_q;
    logic tick;

    state_t            state_q, state_d;
    logic [GRID_W-1:0] x_q, x_d, y_q, y_d, ny;
    logic              dxn_q, dxn_d, dyn_q, dyn_d, ndyn;
    logic [3:0]        sl_q, sl_d, sr_q, sr_d;
    logic [FC_W-1:0]   fcnt_q, fcnt_d;
    logic [3:0]        scnt_q, scnt_d;
    logic              go_q, go_d;
    logic              r_up_eff, r_dn_eff;

    assign tick = vs_q & ~vs_prev_q;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        dxn_d   = dxn_q;
        dyn_d   = dyn_q;
        sl_d    = sl_q;
        sr_d    = sr_q;
        fcnt_d  = fcnt_q;
        scnt_d  = scnt_q;
        ndyn    = dyn_q;
        if (dyn_q) begin
            if (y_q == '0) begin ndyn = 1'b0; ny = GRID_W'(1); end
            else                 ny = y_q - 1'b1;
        end else begin
            if (y_q == GMAX) begin ndyn = 1'b1; ny = GMAX - 1'b1; end
            else                   ny = y_q + 1'b1;
        end

        if (tick) begin
            case (state_q)
                ST_OVER: if (start) begin
                    sl_d    = '0;
                    sr_d    = '0;
                    fcnt_d  = '0;
                    state_d = ST_SERVE;
                end
                ST_SERVE: begin
                    if (fcnt_q == FC_LAST) begin
                        fcnt_d  = '0;
                        scnt_d  = '0;
                        state_d = ST_PLAY;
                    end else begin
                        fcnt_d = fcnt_q + 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (scnt_q != SC_LAST) begin
                        scnt_d = scnt_q + 1'b1;
                    end else begin
                        // Y resolves first; the paddle test uses the resolved row and pre-move mask.
                        scnt_d = '0;
                        y_d    = ny;
                        dyn_d  = ndyn;
                        if (dxn_q && x_q == GRID_W'(1)) begin
                            if (lpaddle[ny]) begin
                                dxn_d = 1'b0;
                                x_d   = GRID_W'(1);
                            end else begin
                                sr_d    = sr_q + 1'b1;
                                dxn_d   = 1'b1;
                                x_d     = CTR;
                                y_d     = CTR;
                                fcnt_d  = '0;
                                state_d = (sr_d == WIN) ? ST_OVER : ST_SERVE;
                            end
                        end else if (!dxn_q && x_q == GMAX - 1'b1) begin
                            if (rpaddle[ny]) begin
                                dxn_d = 1'b1;
                                x_d   = GMAX - 1'b1;
                            end else begin
                                sl_d    = sl_q + 1'b1;
                                dxn_d   = 1'b0;
                                x_d     = CTR;
                                y_d     = CTR;
                                fcnt_d  = '0;
                                state_d = (sl_d == WIN) ? ST_OVER : ST_SERVE;
                            end
                        end else begin
                            x_d = dxn_q ? x_q - 1'b1 : x_q + 1'b1;
                        end
                    end
                end
                default: state_d = ST_OVER;
            endcase
        end
        go_d = (state_d == ST_OVER);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vs_q      <= 1'b1;
            vs_prev_q <= 1'b1;
            state_q   <= ST_OVER;
            x_q       <= CTR;
            y_q       <= CTR;
            dxn_q     <= 1'b0;
            dyn_q     <= 1'b0;
            sl_q      <= '0;
            sr_q      <= '0;
            fcnt_q    <= '0;
            scnt_q    <= '0;
            go_q      <= 1'b1;
        end else begin
            vs_q      <= vsync;
            vs_prev_q <= vs_q;
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            dxn_q     <= dxn_d;
            dyn_q     <= dyn_d;
            sl_q      <= sl_d;
            sr_q      <= sr_d;
            fcnt_q    <= fcnt_d;
            scnt_q    <= scnt_d;
            go_q      <= go_d;
        end
    end

`ifdef PONG_AUTOPADDLE_EN
    localparam logic [GRID_W-1:0] HALF  = GRID_W'(PADDLE_H / 2);
    localparam logic [GRID_W-1:0] P_MAX = GRID_W'(16 - PADDLE_H);
    logic [GRID_W-1:0] r_tgt;
    logic [15:0]       at_or_below, below;

    // Paddle position is the lowest set mask bit, so compare against masks rather than a position.
    always_comb begin
        if (y_q < HALF)                r_tgt = '0;
        else if (y_q - HALF > P_MAX)   r_tgt = P_MAX;
        else                           r_tgt = y_q - HALF;
        below       = (16'd1 << r_tgt) - 16'd1;
        at_or_below = (16'd1 << r_tgt) | below;
        r_up_eff    = (rpaddle & at_or_below) == '0;
        r_dn_eff    = (rpaddle & below) != '0;
    end
`else
    assign r_up_eff = r_up;
    assign r_dn_eff = r_dn;
`endif

    pong_paddle #(.PADDLE_H(PADDLE_H)) u_lpad (
        .clk    (clk),
        .reset  (reset),
        .tick   (tick),
        .en     (state_q != ST_OVER),
        .centre (state_q == ST_OVER && start),
        .up     (l_up),
        .dn     (l_dn),
        .mask   (lpaddle)
    );

    pong_paddle #(.PADDLE_H(PADDLE_H)) u_rpad (
        .clk    (clk),
        .reset  (reset),
        .tick   (tick),
        .en     (state_q != ST_OVER),
        .centre (state_q == ST_OVER && start),
        .up     (r_up_eff),
        .dn     (r_dn_eff),
        .mask   (rpaddle)
    );

    assign ball_x    = x_q;
    assign ball_y    = y_q;
    assign score_l   = sl_q;
    assign score_r   = sr_q;
    assign game_over = go_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Randomized bench for pong_game_ctrl against an integer game model kept in the bench.
module tb_pong_game_ctrl;

    localparam int BD  = 4;
    localparam int PH  = 3;
    localparam int SF  = 60;
    localparam int WS  = 9;
    localparam int PM  = 16 - PH;
    localparam int PC  = PM / 2;

    logic        clk = 1'b0;
    logic        reset, vsync, start, l_up, l_dn, r_up, r_dn;
    logic [3:0]  ball_x, ball_y, score_l, score_r;
    logic [15:0] lpaddle, rpaddle;
    logic        game_over;

    int n_cmp = 0;
    int n_err = 0;

    // model state: st 0=over 1=serve 2=play
    int mst, mx, my, mdx, mdy, mlp, mrp, msl, msr, mfc, msc;

    always #5 clk = ~clk;

    pong_game_ctrl #(.BALL_DIV(BD), .PADDLE_H(PH), .SERVE_FRAMES(SF), .WIN_SCORE(WS)) dut (
        .clk       (clk),
        .reset     (reset),
        .vsync     (vsync),
        .start     (start),
        .l_up      (l_up),
        .l_dn      (l_dn),
        .r_up      (r_up),
        .r_dn      (r_dn),
        .ball_x    (ball_x),
        .ball_y    (ball_y),
        .lpaddle   (lpaddle),
        .rpaddle   (rpaddle),
        .score_l   (score_l),
        .score_r   (score_r),
        .game_over (game_over)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] pmask(input int p);
        return 32'((((1 << PH) - 1) << p) & 16'hFFFF);
    endfunction

    function automatic bit on_paddle(input int p, input int row);
        return (row >= p) && (row < p + PH);
    endfunction

    function automatic int move(input int p, input logic up, input logic dn);
        if (up && !dn) return (p > 0) ? p - 1 : 0;
        if (dn && !up) return (p < PM) ? p + 1 : PM;
        return p;
    endfunction

    task automatic model_reset();
        mst = 0; mx = 7; my = 7; mdx = 1; mdy = 1;
        mlp = PC; mrp = PC; msl = 0; msr = 0; mfc = 0; msc = 0;
    endtask

    task automatic model_tick(input logic s, input logic lu, input logic ld,
                              input logic ru, input logic rd);
        int olp, orp, nx, ny, tgt;
        logic rue, rde;
        olp = mlp;
        orp = mrp;
        rue = ru;
        rde = rd;
`ifdef PONG_AUTOPADDLE_EN
        tgt = my - PH / 2;
        if (tgt < 0) tgt = 0;
        if (tgt > PM) tgt = PM;
        rue = (orp > tgt);
        rde = (orp < tgt);
`else
        tgt = 0;
`endif
        if (mst == 0) begin
            if (s) begin
                msl = 0; msr = 0; mlp = PC; mrp = PC; mst = 1; mfc = 0;
            end
            return;
        end
        mlp = move(olp, lu, ld);
        mrp = move(orp, rue, rde);
        if (mst == 1) begin
            if (mfc == SF - 1) begin mst = 2; mfc = 0; msc = 0; end
            else mfc++;
            return;
        end
        if (msc != BD - 1) begin msc++; return; end
        msc = 0;
        ny = my + mdy;
        if (ny < 0 || ny > 15) begin mdy = -mdy; ny = my + mdy; end
        nx = mx + mdx;
        if (nx == 0) begin
            if (on_paddle(olp, ny)) begin mdx = 1; mx = 1; my = ny; end
            else begin
                msr++; mdx = -1; mx = 7; my = 7; mfc = 0;
                mst = (msr == WS) ? 0 : 1;
            end
        end else if (nx == 15) begin
            if (on_paddle(orp, ny)) begin mdx = -1; mx = 14; my = ny; end
            else begin
                msl++; mdx = 1; mx = 7; my = 7; mfc = 0;
                mst = (msl == WS) ? 0 : 1;
            end
        end else begin
            mx = nx; my = ny;
        end
    endtask

    task automatic check_all();
        chk("ball_x", 32'(ball_x), 32'(mx));
        chk("ball_y", 32'(ball_y), 32'(my));
        chk("lpaddle", 32'(lpaddle), pmask(mlp));
        chk("rpaddle", 32'(rpaddle), pmask(mrp));
        chk("score_l", 32'(score_l), 32'(msl));
        chk("score_r", 32'(score_r), 32'(msr));
        chk("game_over", 32'(game_over), 32'(mst == 0));
    endtask

    task automatic do_frame(input logic s, input logic lu, input logic ld,
                            input logic ru, input logic rd);
        @(negedge clk);
        start = s; l_up = lu; l_dn = ld; r_up = ru; r_dn = rd;
        vsync = 1'b1;
        repeat (2) @(negedge clk);
        vsync = 1'b0;
        repeat (2) @(negedge clk);
        model_tick(s, lu, ld, ru, rd);
        check_all();
    endtask

    initial begin
        reset = 1'b1; vsync = 1'b1; start = 1'b1;
        l_up = 1'b0; l_dn = 1'b0; r_up = 1'b0; r_dn = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        // vsync held high out of reset with start=1 must not produce a tick
        repeat (6) @(negedge clk);
        check_all();
        chk("no_tick_after_reset", 32'(game_over), 32'd1);
        start = 1'b0; vsync = 1'b0;
        repeat (2) @(negedge clk);

        do_frame(1, 0, 0, 0, 0);
        chk("start_enters_serve", 32'(game_over), 32'd0);
        for (int i = 0; i < 6; i++) do_frame(0, 1, 0, 0, 0);
        chk("lpad_top_6", 32'(lpaddle), 32'h0007);
        for (int i = 0; i < 4; i++) do_frame(0, 1, 0, 0, 0);
        chk("lpad_top_10", 32'(lpaddle), 32'h0007);
        for (int i = 0; i < 2; i++) do_frame(0, 1, 1, 0, 0);
        chk("lpad_both_hold", 32'(lpaddle), 32'h0007);
        for (int i = 12; i < SF - 1; i++) do_frame(0, 0, 0, 0, 0);
        chk("serve_hold_x", 32'(ball_x), 32'd7);
        do_frame(0, 0, 0, 0, 0);
        chk("play_entry_y", 32'(ball_y), 32'd7);
        for (int i = 0; i < BD - 1; i++) do_frame(0, 0, 0, 0, 0);
        chk("pre_step_x", 32'(ball_x), 32'd7);
        do_frame(0, 0, 0, 0, 0);
        chk("first_step_x", 32'(ball_x), 32'd8);
        chk("first_step_y", 32'(ball_y), 32'd8);

        for (int i = 0; i < 4000; i++)
            do_frame(logic'($urandom_range(0, 15) == 0),
                     logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
                     logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)));

        // reset asserted mid-frame with vsync high
        @(negedge clk);
        vsync = 1'b1; start = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all();
        start = 1'b0; vsync = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 300; i++)
            do_frame(logic'(i == 0), logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
                     logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pong_game_ctrl.md
PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 Parameter BALL_DIV, default 4, frame ticks per ball step (1..15).
REQ-002 Parameter PADDLE_H, default 3, paddle height in grid cells (1..8).
REQ-003 Parameter SERVE_FRAMES, default 60, frame ticks the ball is held before each serve.
REQ-004 Parameter WIN_SCORE, default 9, score that ends the game (1..15).
REQ-005 clk  in  1  pixel clock, single clock domain; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 vsync  in  1  frame sync from the display timing block; a rising edge is one frame tick.
REQ-008 start  in  1  level; sampled on frame ticks only.
REQ-009 l_up, l_dn, r_up, r_dn  in  1 each  paddle buttons, pre-debounced; sampled on frame ticks only.
REQ-010 ball_x, ball_y  out  4 each  ball grid cell, 0..15.
REQ-011 lpaddle, rpaddle  out  16 each  paddle cell masks; bit n set = row n occupied.
REQ-012 score_l, score_r  out  4 each  scores.
REQ-013 game_over  out  1  high in state OVER.

Function
REQ-014 Frame tick is a one-cycle internal pulse on the cycle after vsync is first seen high following a low sample; no other event advances game state.
REQ-015 FSM states: OVER, SERVE, PLAY; transitions evaluated on frame ticks only.
REQ-016 OVER: ball held at (7,7); start=1 clears both scores, recentres paddles, and enters SERVE.
REQ-017 SERVE: ball held at (7,7); the frame counter counts SERVE_FRAMES ticks, then enters PLAY with the step counter cleared.
REQ-018 PLAY: every BALL_DIV-th tick the ball moves one cell by (dx,dy), dx,dy in {+1,-1}.
REQ-019 Y wall: when the next y would leave 0..15, dy is negated and y moves one cell in the new direction; there is no sticking on the wall row.
REQ-020 Left edge: when the next x is 0 and lpaddle[next y] is 1, dx becomes +1 and x stays at 1 (bounce); otherwise score_r increments and the FSM enters SERVE with dx=-1.
REQ-021 Right edge: mirror of REQ-020, using column 15, rpaddle, score_l, and serve dx=+1.
REQ-022 If an increment makes a score equal WIN_SCORE, the FSM enters OVER instead of SERVE; scores are held until the next start.
REQ-023 Paddle position p is in 0..16-PADDLE_H. On each tick, up alone gives p-1 and down alone gives p+1, both saturating at the ends. Both pressed, or neither: hold. Paddles move in SERVE and PLAY only.
REQ-024 Mask = (2^PADDLE_H - 1) << p, computed 16 bits wide; the outputs are registered.
REQ-025 On a tick where both the paddle and the ball move, the bounce test uses the paddle mask from before the move.
REQ-026 A diagonal step where x and y hit an edge on the same tick resolves Y first, then X using the resolved next y.
REQ-027 All outputs are registered and change only on the cycle after a frame tick.

Reset
REQ-028 Reset state is OVER, with ball (7,7), dx=+1, dy=+1, scores 0, paddle position (16-PADDLE_H)/2 (6 by default), all counters 0, game_over=1.
REQ-029 Reset asserted mid-frame or mid-serve overrides everything on the same edge; the vsync edge detector is also cleared, so the first tick needs a fresh low-to-high transition.

Configuration
REQ-030 Macro PONG_AUTOPADDLE_EN.
- Defined: the right paddle ignores r_up/r_dn. Each tick it moves one cell toward centring on ball_y (target p = ball_y - PADDLE_H/2, saturated), with the same range limits as a button-driven paddle.
- Undefined: the right paddle is button-driven per REQ-023, and the tracking logic is absent.

Structure
REQ-031 Shared package pong_pkg holds the state enum (OVER, SERVE, PLAY), GRID_W=4, GRID_MAX=15, and BALL_CENTRE=7.
REQ-032 One sub-module, pong_paddle, holds position register, saturation, and mask generation; it is instantiated twice (left and right).

Verification
REQ-033 Reset, then start=1 for one tick, then 60 ticks: ball stays at (7,7) until the 60th tick, and the first PLAY step (after 4 more ticks) moves it to (8,8).
REQ-034 Ball at (3,1) with dy=-1, after one step: ball at (2,1)... corrected: ball at (3,0)→ with dx=-1, ball (3,1) steps to (2,0); the next step gives (1,1) with dy=+1.
REQ-035 lpaddle=0x01C0, ball steps into (0,7): bounce; ball at (1,7)... resolved as x=1, dx=+1, scores unchanged.
REQ-036 lpaddle=0x0007, ball steps toward (0,9): score_r goes 0→1, the FSM enters SERVE, the ball returns to (7,7), and the next serve has dx=-1.
REQ-037 score_l=8, right miss: score_l=9, game_over=1, the ball freezes at (7,7), and the buttons have no effect on the paddles.
REQ-038 l_up held 10 ticks from p=6: lpaddle = 0x0007 after 6 ticks and stays there. l_up and l_dn held together: no change.
